frost32_mmio_timer: RTL and testbench

- Memory-mapped interval timer that is a responder on the Frost32Cpu memory port (req_mem_access / addr / data / data_inout_access_type / data_inout_access_size in; data / wait_for_mem out), the other end of the CPU's initiator role.
- Sits beside MainMem on the CPU bus. An external mux uses the `selected` output to choose between this block's data/wait_for_mem and MainMem's.
- Generates the CPU's `interrupt` input in hardware.

---
 rtl/frost32_mmio_timer.sv | 185 ++++++++++++++++++
 tb/tb_frost32_mmio_timer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/frost32_mmio_timer.sv
// Memory-mapped interval timer responding on the Frost32 CPU memory port.
// Four word registers (CTRL, RELOAD, COUNT, STATUS) sit in a 16-byte window;
// every access, legal or not, holds wait_for_mem high for LATENCY cycles.
module frost32_mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_mem_access,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        data_inout_access_type,
  input  logic [1:0]  data_inout_access_size,
  output logic [31:0] data_out,
  output logic        wait_for_mem,
  output logic        selected,
  output logic        interrupt
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [3:0] LatCnt = 4'(LATENCY);

  // Access FSM state and latched request
  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [3:0]  off_q, off_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_out_q, data_out_d;
  logic        wait_q, wait_d;

  // Timer state
  logic [2:0]  ctrl_q, ctrl_d;      // {AUTO_RELOAD, IRQ_EN, EN}
  logic [31:0] reload_q, reload_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;

  logic        commit;
  logic        legal;
  logic        wr_ctrl, wr_reload, wr_status;
  logic        zero_hit;
  logic [31:0] rd_val;

  assign selected     = (addr[31:4] == BASE_ADDR[31:4]);
  assign data_out     = data_out_q;
  assign wait_for_mem = wait_q;
  assign interrupt    = irq_q;

  // Only aligned full-word accesses touch the registers.
  assign legal     = (size_q == 2'd0) && (off_q[1:0] == 2'b00);
  assign wr_ctrl   = commit && wr_q && legal && (off_q[3:2] == 2'd0);
  assign wr_reload = commit && wr_q && legal && (off_q[3:2] == 2'd1);
  assign wr_status = commit && wr_q && legal && (off_q[3:2] == 2'd3);
  assign zero_hit  = ctrl_q[0] && (count_q == 32'd0);

  // Register read mux, indexed by word offset
  always_comb begin
    rd_val = 32'd0;
    case (off_q[3:2])
      2'd0:    rd_val = {29'd0, ctrl_q};
      2'd1:    rd_val = reload_q;
      2'd2:    rd_val = count_q;
      default: rd_val = {31'd0, pending_q};
    endcase
  end

  // Access handshake: accept in idle, count down latency, commit, one idle-out cycle
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    off_d      = off_q;
    wr_d       = wr_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    wait_d     = wait_q;
    data_out_d = data_out_q;
    commit     = 1'b0;
    case (state_q)
      StIdle: begin
        wait_d = 1'b0;
        if (req_mem_access && selected) begin
          off_d   = addr[3:0];
          wr_d    = data_inout_access_type;
          size_d  = data_inout_access_size;
          wdata_d = data_in;
          wcnt_d  = LatCnt;
          wait_d  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          commit  = 1'b1;
          wait_d  = 1'b0;
          state_d = StDone;
          if (!wr_q) begin
            data_out_d = legal ? rd_val : 32'd0;
          end
        end
      end
      StDone: begin
        wait_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        wait_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Timer countdown plus register writes; bus writes override timer-driven EN,
  // while a zero-hit always sets PENDING even against a same-cycle clear.
  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    reload_d  = reload_q;
    pending_d = pending_q;
    if (ctrl_q[0]) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else if (ctrl_q[2]) begin
        count_d = reload_q;
      end else begin
        ctrl_d[0] = 1'b0;
      end
    end
    if (wr_ctrl) begin
      ctrl_d = wdata_q[2:0];
      // Only a 0->1 transition of EN restarts the count.
      if (wdata_q[0] && !ctrl_q[0]) begin
        count_d = reload_q;
      end
    end
    if (wr_reload) begin
      reload_d = wdata_q;
    end
    if (wr_status && wdata_q[0]) begin
      pending_d = 1'b0;
    end
    if (zero_hit) begin
      pending_d = 1'b1;
    end
    irq_d = pending_d & ctrl_d[1];
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wcnt_q     <= 4'd0;
      off_q      <= 4'd0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      wdata_q    <= 32'd0;
      data_out_q <= 32'd0;
      wait_q     <= 1'b0;
      ctrl_q     <= 3'd0;
      reload_q   <= 32'd0;
      count_q    <= 32'd0;
      pending_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      off_q      <= off_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      wait_q     <= wait_d;
      ctrl_q     <= ctrl_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_frost32_mmio_timer.sv
// Directed bench for frost32_mmio_timer. Bus stimulus pushes the expected
// completion (wait length, read data) into a queue; a negedge monitor pops
// and compares whenever wait_for_mem falls.
module tb_frost32_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int unsigned LAT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_mem_access = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic        data_inout_access_type = 1'b0;
  logic [1:0]  data_inout_access_size = 2'd0;
  logic [31:0] data_out;
  logic        wait_for_mem;
  logic        selected;
  logic        interrupt;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int unsigned len;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  frost32_mmio_timer #(
    .BASE_ADDR(BASE),
    .LATENCY  (LAT)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_mem_access        (req_mem_access),
    .addr                  (addr),
    .data_in               (data_in),
    .data_inout_access_type(data_inout_access_type),
    .data_inout_access_size(data_inout_access_size),
    .data_out              (data_out),
    .wait_for_mem          (wait_for_mem),
    .selected              (selected),
    .interrupt             (interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access; returns just after the completing edge.
  task automatic bus(input string nm, input logic [31:0] a, input logic wr,
                     input logic [1:0] sz, input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    tick();
    e.is_read = !wr;
    e.data    = exp_rd;
    e.len     = LAT;
    e.name    = nm;
    sb_q.push_back(e);
    req_mem_access         = 1'b1;
    addr                   = a;
    data_inout_access_type = wr;
    data_inout_access_size = sz;
    data_in                = wd;
    tick();
    req_mem_access = 1'b0;
    for (int i = 0; i < 20 && wait_for_mem; i++) tick();
    chk({nm, "_timeout"}, 32'(wait_for_mem), 32'd0);
  endtask

  // Scoreboard monitor: measure wait length and compare read data on completion.
  initial begin : monitor
    int   hi;
    exp_t e;
    hi = 0;
    forever begin
      @(negedge clk);
      if (wait_for_mem) begin
        hi++;
      end else if (hi != 0) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion: got wait length %0d expected no access", hi);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_wait_len"}, 32'(hi), 32'(e.len));
          if (e.is_read) chk({e.name, "_data"}, data_out, e.data);
        end
        hi = 0;
      end
    end
  end

  initial begin : stim
    exp_t e;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_wait", 32'(wait_for_mem), 32'd0);
    chk("rst_irq", 32'(interrupt), 32'd0);
    chk("sel_outside", 32'(selected), 32'd0);
    rst = 1'b0;
    bus("rd_count_rst", BASE + 32'h8, 1'b0, 2'd0, 32'd0, 32'd0);

    // Auto-reload, period 4
    bus("wr_reload3", BASE + 32'h4, 1'b1, 2'd0, 32'd3, 32'd0);
    bus("wr_ctrl7", BASE + 32'h0, 1'b1, 2'd0, 32'd7, 32'd0);
    chk("irq_at_enable", 32'(interrupt), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i <= 3) chk("irq_before_hit", 32'(interrupt), 32'd0);
      if (i == 5) chk("irq_after_hit", 32'(interrupt), 32'd1);
    end
    bus("rd_count_a", BASE + 32'h8, 1'b0, 2'd0, 32'd0, 32'd3);
    tick();
    bus("rd_count_b", BASE + 32'h8, 1'b0, 2'd0, 32'd0, 32'd2);
    tick();
    bus("rd_count_c", BASE + 32'h8, 1'b0, 2'd0, 32'd0, 32'd1);
    tick();
    bus("rd_count_d", BASE + 32'h8, 1'b0, 2'd0, 32'd0, 32'd0);
    tick();
    bus("wr_ctrl6_stop", BASE + 32'h0, 1'b1, 2'd0, 32'd6, 32'd0);
    chk("irq_held_stopped", 32'(interrupt), 32'd1);
    bus("wr_status_clr", BASE + 32'hC, 1'b1, 2'd0, 32'd1, 32'd0);
    chk("irq_after_clr", 32'(interrupt), 32'd0);
    bus("rd_status_clr", BASE + 32'hC, 1'b0, 2'd0, 32'd0, 32'd0);
    bus("rd_count_frozen", BASE + 32'h8, 1'b0, 2'd0, 32'd0, 32'd2);
    bus("rd_ctrl6", BASE + 32'h0, 1'b0, 2'd0, 32'd0, 32'd6);

    // Clear on the exact zero-hit edge: set wins
    bus("wr_ctrl7_b", BASE + 32'h0, 1'b1, 2'd0, 32'd7, 32'd0);
    bus("wr_status_on_hit", BASE + 32'hC, 1'b1, 2'd0, 32'd1, 32'd0);
    chk("irq_set_wins", 32'(interrupt), 32'd1);
    tick();
    bus("wr_status_clr_b", BASE + 32'hC, 1'b1, 2'd0, 32'd1, 32'd0);
    chk("irq_clr_b", 32'(interrupt), 32'd0);
    repeat (3) tick();
    // Disable on the exact zero-hit edge: EN cleared, PENDING still set
    bus("wr_ctrl0_on_hit", BASE + 32'h0, 1'b1, 2'd0, 32'd0, 32'd0);
    chk("irq_off_no_irqen", 32'(interrupt), 32'd0);
    bus("rd_status_hit", BASE + 32'hC, 1'b0, 2'd0, 32'd0, 32'd1);
    bus("rd_ctrl0", BASE + 32'h0, 1'b0, 2'd0, 32'd0, 32'd0);
    bus("rd_count_reloaded", BASE + 32'h8, 1'b0, 2'd0, 32'd0, 32'd3);
    bus("wr_status_clr_c", BASE + 32'hC, 1'b1, 2'd0, 32'd1, 32'd0);

    // One-shot, RELOAD=5
    bus("wr_reload5", BASE + 32'h4, 1'b1, 2'd0, 32'd5, 32'd0);
    bus("wr_ctrl3", BASE + 32'h0, 1'b1, 2'd0, 32'd3, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) chk("oneshot_irq_early", 32'(interrupt), 32'd0);
      else chk("oneshot_irq", 32'(interrupt), 32'd1);
    end
    bus("rd_ctrl_oneshot", BASE + 32'h0, 1'b0, 2'd0, 32'd0, 32'd2);
    bus("rd_count_oneshot", BASE + 32'h8, 1'b0, 2'd0, 32'd0, 32'd0);
    bus("rd_status_oneshot", BASE + 32'hC, 1'b0, 2'd0, 32'd0, 32'd1);
    chk("oneshot_irq_held", 32'(interrupt), 32'd1);
    bus("wr_status_clr_d", BASE + 32'hC, 1'b1, 2'd0, 32'd1, 32'd0);
    chk("oneshot_irq_clr", 32'(interrupt), 32'd0);

    // Illegal accesses: full handshake, read zero, write ignored
    bus("rd_ill_size2", BASE + 32'h4, 1'b0, 2'd2, 32'd0, 32'd0);
    bus("rd_ill_size1", BASE + 32'h0, 1'b0, 2'd1, 32'd0, 32'd0);
    bus("wr_ill_unal", BASE + 32'h2, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'd0);
    bus("wr_ill_size2", BASE + 32'h4, 1'b1, 2'd2, 32'h77, 32'd0);
    bus("wr_ill_unal6", BASE + 32'h6, 1'b1, 2'd0, 32'h88, 32'd0);
    bus("rd_ctrl_kept", BASE + 32'h0, 1'b0, 2'd0, 32'd0, 32'd2);
    bus("rd_reload_kept", BASE + 32'h4, 1'b0, 2'd0, 32'd0, 32'd5);

    // Reset during WAIT of a RELOAD write
    tick();
    e.is_read = 1'b0;
    e.data    = 32'd0;
    e.len     = 1;
    e.name    = "wr_reload_abort";
    sb_q.push_back(e);
    req_mem_access         = 1'b1;
    addr                   = BASE + 32'h4;
    data_inout_access_type = 1'b1;
    data_inout_access_size = 2'd0;
    data_in                = 32'h1234;
    tick();
    req_mem_access = 1'b0;
    chk("abort_wait_high", 32'(wait_for_mem), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_wait_low", 32'(wait_for_mem), 32'd0);
    chk("abort_data_out", data_out, 32'd0);
    bus("rd_reload_abort", BASE + 32'h4, 1'b0, 2'd0, 32'd0, 32'd0);
    bus("rd_ctrl_abort", BASE + 32'h0, 1'b0, 2'd0, 32'd0, 32'd0);

    // Outside the window: no response
    addr = BASE + 32'hC;
    #1;
    chk("sel_inside", 32'(selected), 32'd1);
    tick();
    addr                   = 32'h0000_1008;
    data_inout_access_type = 1'b0;
    req_mem_access         = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("outside_sel", 32'(selected), 32'd0);
      chk("outside_wait", 32'(wait_for_mem), 32'd0);
    end
    req_mem_access = 1'b0;

    tick();
    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
